// File: rtl/featuremap_pad_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : featuremap_pad_writer_pkg
// Description : Shared constants, FSM encoding and sizing helpers for the
//               per-channel zero-padding feature-map writer.
// Revision    : 1.0 - initial release
// ============================================================================
package featuremap_pad_writer_pkg;

    // Padding adds one ring of pixels on every side of the map.
    localparam int c_PAD_RING = 2;

    // Pad pixels are IEEE-754 +0.0.
    localparam logic [31:0] c_PAD_VALUE = 32'h0000_0000;

    // Writer FSM encoding.
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t c_ST_IDLE = 2'd0;
    localparam fsm_state_t c_ST_RUN  = 2'd1;
    localparam fsm_state_t c_ST_LAST = 2'd2;

    // Side length of the padded raster.
    function automatic int padded_side(input int width);
        return width + c_PAD_RING;
    endfunction

    // Ceiling log2, used to size counters and buffer pointers.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/featuremap_pad_buffer.sv
`default_nettype none
// ============================================================================
// Module      : featuremap_pad_buffer
// Description : Synchronous first-word-fall-through FIFO that absorbs input
//               pixels while the writer is busy emitting padding.
// Revision    : 1.0 - initial release
// ============================================================================
module featuremap_pad_buffer
    import featuremap_pad_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = clog2(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    // A pop on a full buffer frees the slot the same-cycle push lands in.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign dout  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/featuremap_pad_writer.sv
`default_nettype none
// ============================================================================
// Module      : featuremap_pad_writer
// Description : Converts an unpadded WIDTH x WIDTH raster into a zero-padded
//               (WIDTH+2) x (WIDTH+2) raster written to a downstream FIFO,
//               buffering input pixels while padding is inserted.
// Revision    : 1.0 - initial release
// ============================================================================
module featuremap_pad_writer
    import featuremap_pad_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int BUF_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow
);

    localparam int                    SIDE       = padded_side(WIDTH);
    localparam int                    CNT_W      = clog2(SIDE);
    localparam logic [CNT_W-1:0]      c_LAST_IDX = CNT_W'(SIDE - 1);
    localparam logic [DATA_WIDTH-1:0] c_PAD_WORD = DATA_WIDTH'(c_PAD_VALUE);

    fsm_state_t            r_state;
    fsm_state_t            w_state_nxt;
    logic [CNT_W-1:0]      r_row;
    logic [CNT_W-1:0]      r_col;
    logic [CNT_W-1:0]      w_row_nxt;
    logic [CNT_W-1:0]      w_col_nxt;
    logic                  w_is_pad;
    logic                  w_last_pos;
    logic                  w_emit;
    logic                  w_pop;
    logic                  w_buf_empty;
    logic                  w_buf_full;
    logic [DATA_WIDTH-1:0] w_buf_head;

    logic                  r_wrreq;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_frame_done;
    logic                  r_busy;
    logic                  r_overflow;

    // Input pixels always go to the buffer; it drops them itself when full.
    featuremap_pad_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_buf_head),
        .empty (w_buf_empty),
        .full  (w_buf_full)
    );

    assign w_is_pad   = (r_row == '0) || (r_row == c_LAST_IDX) ||
                        (r_col == '0) || (r_col == c_LAST_IDX);
    assign w_last_pos = (r_row == c_LAST_IDX) && (r_col == c_LAST_IDX);
    // Only interior positions consume a buffered pixel.
    assign w_pop      = w_emit && !w_is_pad;

    // Next-state, raster position advance and emit decision.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_emit      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_buf_empty || valid_in) begin
                    w_state_nxt = c_ST_RUN;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            c_ST_RUN: begin
                // Pad positions never wait on input; interior ones need data.
                if (!fifo_full && (w_is_pad || !w_buf_empty)) begin
                    w_emit = 1'b1;
                    if (w_last_pos) begin
                        w_state_nxt = c_ST_LAST;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                    end else if (r_col == c_LAST_IDX) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + CNT_W'(1);
                    end else begin
                        w_col_nxt = r_col + CNT_W'(1);
                    end
                end
            end
            c_ST_LAST: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM state and raster position registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Registered write port and status; data_out holds its value across stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrreq      <= 1'b0;
            r_data_out   <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_wrreq      <= w_emit;
            r_frame_done <= w_emit && w_last_pos;
            r_busy       <= (r_state != c_ST_IDLE) || !w_buf_empty;
            if (w_emit) begin
                r_data_out <= w_is_pad ? c_PAD_WORD : w_buf_head;
            end
            if (valid_in && w_buf_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wrreq      = r_wrreq;
    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_featuremap_pad_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_featuremap_pad_writer
// Description : Self-checking bench for featuremap_pad_writer against a
//               raster-level padding model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_featuremap_pad_writer;

    localparam int W    = 4;
    localparam int DW   = 32;
    localparam int SIDE = W + 2;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: roomy buffer. Instance B: tiny buffer for overflow.
    logic          rst_a = 1'b0, valid_a = 1'b0, fifo_full_a = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic          wrreq_a, frame_done_a, busy_a, overflow_a;
    logic [DW-1:0] data_out_a;
    logic          rst_b = 1'b0, valid_b = 1'b0, fifo_full_b = 1'b0;
    logic [DW-1:0] data_b = '0;
    logic          wrreq_b, frame_done_b, busy_b, overflow_b;
    logic [DW-1:0] data_out_b;

    featuremap_pad_writer #(.DATA_WIDTH(DW), .WIDTH(W), .BUF_DEPTH(128)) u_dut (
        .clk(clk), .rst(rst_a), .valid_in(valid_a), .data_in(data_a),
        .fifo_full(fifo_full_a), .wrreq(wrreq_a), .data_out(data_out_a),
        .frame_done(frame_done_a), .busy(busy_a), .overflow(overflow_a));

    featuremap_pad_writer #(.DATA_WIDTH(DW), .WIDTH(W), .BUF_DEPTH(4)) u_dut_ovf (
        .clk(clk), .rst(rst_b), .valid_in(valid_b), .data_in(data_b),
        .fifo_full(fifo_full_b), .wrreq(wrreq_b), .data_out(data_out_b),
        .frame_done(frame_done_b), .busy(busy_b), .overflow(overflow_b));

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard state.
    logic [DW-1:0] exp_pix[$];
    logic [DW-1:0] cap_data[$];
    bit            cap_fd[$];
    int            cap_cyc[$];
    logic [DW-1:0] capb[$];
    int            cyc = 0;
    int            first_drive_cyc = 0;
    int            fd_cyc = 0;
    int            busy_fall_cyc = 0;
    int            bp_mode = 0;

    // Backpressure pattern for instance A.
    always @(negedge clk) begin
        case (bp_mode)
            1:       fifo_full_a = ~fifo_full_a;
            2:       fifo_full_a = 1'($urandom_range(0, 1));
            default: fifo_full_a = 1'b0;
        endcase
    end

    // Monitor A: capture writes, check write gating and data hold.
    logic          ff_edge, rst_edge, prev_busy = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(posedge clk) begin
        ff_edge  = fifo_full_a;
        rst_edge = rst_a;
        cyc++;
        #1;
        if (rst_edge) begin
            if (wrreq_a) begin
                cap_data.push_back(data_out_a);
                cap_fd.push_back(frame_done_a);
                cap_cyc.push_back(cyc);
                check_value("write_under_full", 32'(ff_edge), 32'd0);
            end else begin
                check_value("stall_hold", data_out_a, prev_data);
            end
            if (frame_done_a) begin
                fd_cyc = cyc;
                check_value("fd_with_wr", 32'(wrreq_a), 32'd1);
            end
            if (prev_busy && !busy_a) busy_fall_cyc = cyc;
        end
        prev_data = data_out_a;
        prev_busy = busy_a;
    end

    // Monitor B: capture writes only.
    always @(posedge clk) begin
        #1;
        if (wrreq_b) capb.push_back(data_out_b);
    end

    // gap < 0 selects a random gap of 0..2 idle cycles per pixel.
    task automatic send_pixels(input int n, input int gap, input bit rnd, input int base);
        int g;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first_drive_cyc = cyc;
            valid_a = 1'b1;
            data_a  = rnd ? $urandom : DW'(base + i);
            exp_pix.push_back(data_a);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                valid_a = 1'b0;
            end
        end
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy_a || wrreq_a) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check_value({tag, "_idle"}, 32'(busy_a), 32'd0);
        check_value({tag, "_no_ovf"}, 32'(overflow_a), 32'd0);
    endtask

    // Reference: raster scan of the padded map, interior filled in arrival order.
    task automatic check_frames(input string tag);
        int            nf, k, idx;
        bit            pad, efd;
        logic [DW-1:0] ev;
        nf  = exp_pix.size() / (W * W);
        k   = 0;
        idx = 0;
        check_value({tag, "_writes"}, 32'(cap_data.size()), 32'(nf * SIDE * SIDE));
        for (int f = 0; f < nf; f++) begin
            for (int r = 0; r < SIDE; r++) begin
                for (int c = 0; c < SIDE; c++) begin
                    pad = (r == 0) || (r == SIDE - 1) || (c == 0) || (c == SIDE - 1);
                    ev  = '0;
                    if (!pad) begin
                        ev = exp_pix[k];
                        k++;
                    end
                    efd = (r == SIDE - 1) && (c == SIDE - 1);
                    if (idx < cap_data.size()) begin
                        check_value({tag, "_data"}, cap_data[idx], ev);
                        check_value({tag, "_fd"}, 32'(cap_fd[idx]), 32'(efd));
                    end
                    idx++;
                end
            end
        end
    endtask

    task automatic clear_scoreboard();
        exp_pix.delete();
        cap_data.delete();
        cap_fd.delete();
        cap_cyc.delete();
    endtask

    initial begin
        int k;
        // Reset state.
        repeat (3) @(negedge clk);
        check_value("rst_wrreq", 32'(wrreq_a), 32'd0);
        check_value("rst_data", data_out_a, 32'd0);
        check_value("rst_fd", 32'(frame_done_a), 32'd0);
        check_value("rst_busy", 32'(busy_a), 32'd0);
        check_value("rst_ovf", 32'(overflow_a), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Overflow on a 4-deep buffer with the downstream FIFO held full.
        fifo_full_b = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            @(negedge clk);
            valid_b = 1'b1;
            data_b  = DW'(p);
            @(posedge clk);
            #1;
            check_value("ovf_after_px", 32'(overflow_b), 32'(p >= 5));
        end
        @(negedge clk);
        valid_b     = 1'b0;
        fifo_full_b = 1'b0;
        repeat (40) @(negedge clk);
        check_value("ovf_sticky", 32'(overflow_b), 32'd1);
        check_value("ovf_writes", 32'(capb.size()), 32'd13);
        for (int p = 0; p < 13; p++) begin
            int r, c;
            r = p / SIDE;
            c = p % SIDE;
            if (p < capb.size())
                check_value("ovf_data", capb[p],
                            (r == 0 || c == 0 || c == SIDE - 1) ? 32'd0 : 32'((r - 1) * W + c));
        end
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        check_value("ovf_cleared", 32'(overflow_b), 32'd0);
        check_value("ovf_busy_cleared", 32'(busy_b), 32'd0);

        // Basic frame, pixels 1..16 back to back.
        clear_scoreboard();
        bp_mode = 0;
        send_pixels(16, 0, 1'b0, 1);
        wait_idle("basic");
        check_frames("basic");
        if (cap_cyc.size() > 0)
            check_value("basic_latency", 32'(cap_cyc[0] - first_drive_cyc), 32'd2);
        check_value("busy_drop", 32'(busy_fall_cyc - fd_cyc), 32'd2);

        // Same stream with the downstream FIFO toggling full.
        clear_scoreboard();
        bp_mode = 1;
        send_pixels(16, 0, 1'b0, 1);
        wait_idle("bp");
        bp_mode = 0;
        check_frames("bp");

        // Starved input: 3 idle cycles between pixels.
        clear_scoreboard();
        send_pixels(16, 3, 1'b0, 1);
        wait_idle("starve");
        check_frames("starve");
        if (cap_cyc.size() >= SIDE * SIDE) begin
            check_value("starve_latency", 32'(cap_cyc[0] - first_drive_cyc), 32'd2);
            check_value("starve_top_rush", 32'(cap_cyc[SIDE] - cap_cyc[0]), 32'(SIDE));
            check_value("starve_waited", 32'((cap_cyc[SIDE*SIDE-1] - cap_cyc[0]) > SIDE*SIDE - 1), 32'd1);
        end

        // Back-to-back frames of random data.
        clear_scoreboard();
        send_pixels(32, 0, 1'b1, 0);
        wait_idle("b2b");
        check_frames("b2b");

        // Random gaps and random backpressure over two frames.
        clear_scoreboard();
        bp_mode = 2;
        send_pixels(32, -1, 1'b1, 0);
        wait_idle("rand");
        bp_mode = 0;
        check_frames("rand");

        // Reset after the 10th write of a partial frame.
        clear_scoreboard();
        send_pixels(6, 0, 1'b0, 100);
        k = 0;
        while (cap_data.size() < 10 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_value("rst_mid_reached", 32'(cap_data.size()), 32'd10);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        check_value("rst_mid_wrreq", 32'(wrreq_a), 32'd0);
        check_value("rst_mid_ovf", 32'(overflow_a), 32'd0);
        check_value("rst_mid_busy", 32'(busy_a), 32'd0);
        repeat (10) @(negedge clk);
        check_value("rst_mid_quiet", 32'(cap_data.size()), 32'd10);
        clear_scoreboard();
        send_pixels(16, 0, 1'b1, 0);
        wait_idle("after_rst");
        check_frames("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
